// File: rtl/cr_xp10_decomp_sdd_bitbuf_if.sv
// Error-code package and the formatter/decoder-facing bundle of the SDD bit buffer.
// The buffer binds to the slave modport; the driving environment binds to master.
package cr_xp10_decomp_sdd_bitbuf_pkg;
    typedef enum logic [3:0] {
        ZIP_NO_ERR  = 4'd0,
        ZIP_BLK_ERR = 4'd1,
        ZIP_EOF_ERR = 4'd2,
        ZIP_HDR_ERR = 4'd3
    } zipline_error_e;
endpackage

// Handshake: a beat transfers on a cycle where wf_lanes_valid && lanes_wf_ready at posedge;
// the consumer may take up to min(bb_fill, 64) bits only while bb_valid is high.
interface cr_xp10_decomp_sdd_bitbuf_if #(
    parameter int BUF_BITS = 256,
    parameter int WIN_BITS = 64
);
    import cr_xp10_decomp_sdd_bitbuf_pkg::*;

    logic                              wf_lanes_valid;
    logic [127:0]                      wf_lanes_data;
    logic [7:0]                        wf_lanes_numbits;
    logic                              wf_lanes_sob;
    logic                              wf_lanes_eob;
    logic                              wf_lanes_eof;
    logic                              wf_lanes_trace_bit;
    zipline_error_e                    wf_lanes_errcode;
    logic                              lanes_wf_ready;
    logic                              bb_valid;
    logic [WIN_BITS-1:0]               bb_data;
    logic [$clog2(BUF_BITS+1)-1:0]     bb_fill;
    logic                              bb_sob;
    logic                              bb_eob;
    logic                              bb_eof;
    logic                              bb_trace_bit;
    zipline_error_e                    bb_errcode;
    logic [$clog2(WIN_BITS+1)-1:0]     bb_consume;
    logic                              bb_overrun_err;

    modport slave (
        input  wf_lanes_valid, wf_lanes_data, wf_lanes_numbits, wf_lanes_sob,
               wf_lanes_eob, wf_lanes_eof, wf_lanes_trace_bit, wf_lanes_errcode,
               bb_consume,
        output lanes_wf_ready, bb_valid, bb_data, bb_fill, bb_sob, bb_eob, bb_eof,
               bb_trace_bit, bb_errcode, bb_overrun_err
    );

    modport master (
        output wf_lanes_valid, wf_lanes_data, wf_lanes_numbits, wf_lanes_sob,
               wf_lanes_eob, wf_lanes_eof, wf_lanes_trace_bit, wf_lanes_errcode,
               bb_consume,
        input  lanes_wf_ready, bb_valid, bb_data, bb_fill, bb_sob, bb_eob, bb_eof,
               bb_trace_bit, bb_errcode, bb_overrun_err
    );
endinterface

// File: rtl/cr_xp10_decomp_sdd_bitbuf.sv
// Bit-granular staging buffer between the SDD width formatter and the symbol decoder.
// Holds up to BUF_BITS LSB-first bits and never lets two blocks share the output window.
module cr_xp10_decomp_sdd_bitbuf
    import cr_xp10_decomp_sdd_bitbuf_pkg::*;
#(
    parameter int BUF_BITS = 256,
    parameter int WIN_BITS = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    cr_xp10_decomp_sdd_bitbuf_if.slave   bus
);
    localparam int LANE = 128;
    localparam int FW   = $clog2(BUF_BITS + 1);

    typedef enum logic {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                sob_pending_q, sob_pending_d;
    logic                eof_flag_q, eof_flag_d;
    logic                trace_q, trace_d;
    zipline_error_e      errcode_q, errcode_d;
    logic                overrun_q, overrun_d;

    logic                valid_w;
    logic                ready_w;
    logic                accept;
    logic                nb_big;
    logic [7:0]          nb;
    logic [LANE-1:0]     beat;
    logic [FW-1:0]       lim;
    logic [FW-1:0]       consume_w;
    logic [FW-1:0]       eff;
    logic [FW-1:0]       offset;
    logic                consume_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            buf_q         <= '0;
            fill_q        <= '0;
            sob_pending_q <= 1'b0;
            eof_flag_q    <= 1'b0;
            trace_q       <= 1'b0;
            errcode_q     <= ZIP_NO_ERR;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            sob_pending_q <= sob_pending_d;
            eof_flag_q    <= eof_flag_d;
            trace_q       <= trace_d;
            errcode_q     <= errcode_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sob_pending_d = sob_pending_q;
        eof_flag_d    = eof_flag_q;
        trace_d       = trace_q;
        errcode_d     = errcode_q;

        // A drained-but-empty block still shows one valid cycle as its end marker.
        valid_w   = (fill_q >= FW'(WIN_BITS)) || (state_q == ST_DRAIN);
        ready_w   = !rst && (fill_q <= FW'(BUF_BITS - LANE)) && (state_q == ST_FILL);
        accept    = bus.wf_lanes_valid && ready_w;

        nb_big    = bus.wf_lanes_numbits > 8'(LANE);
        nb        = nb_big ? 8'(LANE) : bus.wf_lanes_numbits;
        beat      = bus.wf_lanes_data & ~({LANE{1'b1}} << nb);

        lim         = (fill_q >= FW'(WIN_BITS)) ? FW'(WIN_BITS) : fill_q;
        consume_w   = FW'(bus.bb_consume);
        consume_bad = valid_w ? (consume_w > lim) : (consume_w != '0);
        eff         = valid_w ? ((consume_w > lim) ? lim : consume_w) : '0;
        offset      = fill_q - eff;

        // Bits above fill stay zero, so OR-ing the masked beat in at the fill offset is safe.
        buf_d = buf_q >> eff;
        if (accept) begin
            buf_d = buf_d | ({{(BUF_BITS - LANE){1'b0}}, beat} << offset);
        end
        fill_d = fill_q - eff + (accept ? FW'(nb) : '0);

        overrun_d = consume_bad || (accept && nb_big);

        case (state_q)
            ST_FILL: begin
                if (accept && (bus.wf_lanes_eob || bus.wf_lanes_eof)) begin
                    state_d    = ST_DRAIN;
                    errcode_d  = bus.wf_lanes_errcode;
                    eof_flag_d = bus.wf_lanes_eof;
                end
            end
            ST_DRAIN: begin
                if (fill_d == '0) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (accept && bus.wf_lanes_sob) begin
            sob_pending_d = 1'b1;
            trace_d       = bus.wf_lanes_trace_bit;
        end else if ((eff != '0) || ((state_q == ST_DRAIN) && (fill_d == '0))) begin
            sob_pending_d = 1'b0;
        end
    end

    assign bus.lanes_wf_ready = ready_w;
    assign bus.bb_valid       = valid_w;
    assign bus.bb_data        = buf_q[WIN_BITS-1:0];
    assign bus.bb_fill        = fill_q;
    assign bus.bb_sob         = sob_pending_q;
    assign bus.bb_eob         = (state_q == ST_DRAIN) && (fill_q <= FW'(WIN_BITS));
    assign bus.bb_eof         = bus.bb_eob && eof_flag_q;
    assign bus.bb_trace_bit   = trace_q;
    assign bus.bb_errcode     = errcode_q;
    assign bus.bb_overrun_err = overrun_q;

endmodule

// File: tb/tb_cr_xp10_decomp_sdd_bitbuf.sv
// Directed bench for the SDD bit buffer: fill/drain, block isolation, mixed
// consume+accept, overrun pulses, empty-end marker and reset.
module tb_cr_xp10_decomp_sdd_bitbuf;
    import cr_xp10_decomp_sdd_bitbuf_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [127:0] pa;
    logic [127:0] pb;
    logic [127:0] pc;
    logic [127:0] ones;

    cr_xp10_decomp_sdd_bitbuf_if #(.BUF_BITS(256), .WIN_BITS(64)) bus ();

    cr_xp10_decomp_sdd_bitbuf #(.BUF_BITS(256), .WIN_BITS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pa   = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        pb   = {64'h0F0F0F0F0F0F0F0F, 64'hDEADBEEFCAFEF00D};
        pc   = 128'hFFFF_FFFF_FFFF_ABCD_0123_4567_89AB_CDEF;
        ones = '1;

        rst                    = 1'b1;
        bus.wf_lanes_valid     = 1'b0;
        bus.wf_lanes_data      = '0;
        bus.wf_lanes_numbits   = '0;
        bus.wf_lanes_sob       = 1'b0;
        bus.wf_lanes_eob       = 1'b0;
        bus.wf_lanes_eof       = 1'b0;
        bus.wf_lanes_trace_bit = 1'b0;
        bus.wf_lanes_errcode   = ZIP_NO_ERR;
        bus.bb_consume         = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", bus.lanes_wf_ready, 0);
        chk("rst_fill", bus.bb_fill, 0);
        chk("rst_valid", bus.bb_valid, 0);
        chk("rst_ovr", bus.bb_overrun_err, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", bus.lanes_wf_ready, 1);

        // Two full beats, then four 64-bit consumes
        bus.wf_lanes_valid   = 1'b1;
        bus.wf_lanes_numbits = 8'd128;
        bus.wf_lanes_data    = pa;
        tick();
        chk("t1_fill128", bus.bb_fill, 128);
        chk("t1_valid", bus.bb_valid, 1);
        chk("t1_data_a0", bus.bb_data, pa[63:0]);
        chk("t1_ready128", bus.lanes_wf_ready, 1);
        bus.wf_lanes_data = pb;
        tick();
        bus.wf_lanes_valid = 1'b0;
        chk("t1_fill256", bus.bb_fill, 256);
        chk("t1_ready256", bus.lanes_wf_ready, 0);
        chk("t1_data_hold", bus.bb_data, pa[63:0]);
        bus.bb_consume = 7'd64;
        tick();
        chk("t1_fill192", bus.bb_fill, 192);
        chk("t1_data_a1", bus.bb_data, pa[127:64]);
        chk("t1_eob0", bus.bb_eob, 0);
        tick();
        chk("t1_fill128b", bus.bb_fill, 128);
        chk("t1_data_b0", bus.bb_data, pb[63:0]);
        chk("t1_ready_back", bus.lanes_wf_ready, 1);
        tick();
        chk("t1_fill64", bus.bb_fill, 64);
        chk("t1_data_b1", bus.bb_data, pb[127:64]);
        chk("t1_eob0b", bus.bb_eob, 0);
        tick();
        bus.bb_consume = '0;
        chk("t1_fill0", bus.bb_fill, 0);
        chk("t1_valid0", bus.bb_valid, 0);
        chk("t1_ovr", bus.bb_overrun_err, 0);

        // Single 40-bit block with sob+eob, masked upper data
        bus.wf_lanes_valid     = 1'b1;
        bus.wf_lanes_numbits   = 8'd40;
        bus.wf_lanes_data      = ones;
        bus.wf_lanes_sob       = 1'b1;
        bus.wf_lanes_eob       = 1'b1;
        bus.wf_lanes_trace_bit = 1'b1;
        bus.wf_lanes_errcode   = ZIP_BLK_ERR;
        tick();
        bus.wf_lanes_valid     = 1'b0;
        bus.wf_lanes_sob       = 1'b0;
        bus.wf_lanes_eob       = 1'b0;
        bus.wf_lanes_trace_bit = 1'b0;
        bus.wf_lanes_errcode   = ZIP_NO_ERR;
        chk("t2_valid", bus.bb_valid, 1);
        chk("t2_fill", bus.bb_fill, 40);
        chk("t2_sob", bus.bb_sob, 1);
        chk("t2_eob", bus.bb_eob, 1);
        chk("t2_eof", bus.bb_eof, 0);
        chk("t2_ready", bus.lanes_wf_ready, 0);
        chk("t2_data", bus.bb_data, 64'h00000000_FF_FFFFFFFF);
        chk("t2_trace", bus.bb_trace_bit, 1);
        chk("t2_errcode", bus.bb_errcode, ZIP_BLK_ERR);
        bus.bb_consume = 7'd40;
        tick();
        bus.bb_consume = '0;
        chk("t2_fill0", bus.bb_fill, 0);
        chk("t2_ready1", bus.lanes_wf_ready, 1);
        chk("t2_valid0", bus.bb_valid, 0);
        chk("t2_sob0", bus.bb_sob, 0);
        chk("t2_ovr", bus.bb_overrun_err, 0);

        // Block A (10 bits, eob) then block B offered while A drains
        bus.wf_lanes_valid   = 1'b1;
        bus.wf_lanes_numbits = 8'd10;
        bus.wf_lanes_data    = 128'h2AB;
        bus.wf_lanes_eob     = 1'b1;
        tick();
        bus.wf_lanes_data    = pc;
        bus.wf_lanes_numbits = 8'd80;
        bus.wf_lanes_sob     = 1'b1;
        bus.wf_lanes_eob     = 1'b0;
        chk("t3_ready0", bus.lanes_wf_ready, 0);
        chk("t3_fill10", bus.bb_fill, 10);
        chk("t3_data_a", bus.bb_data, 64'h2AB);
        chk("t3_eob", bus.bb_eob, 1);
        tick();
        chk("t3_fill_hold", bus.bb_fill, 10);
        chk("t3_data_hold", bus.bb_data, 64'h2AB);
        bus.bb_consume = 7'd10;
        tick();
        bus.bb_consume = '0;
        chk("t3_drained", bus.bb_fill, 0);
        chk("t3_ready1", bus.lanes_wf_ready, 1);
        chk("t3_valid0", bus.bb_valid, 0);
        chk("t3_data0", bus.bb_data, 64'h0);
        tick();
        bus.wf_lanes_valid = 1'b0;
        bus.wf_lanes_sob   = 1'b0;
        chk("t3_fill80", bus.bb_fill, 80);
        chk("t3_data_b", bus.bb_data, 64'h0123456789ABCDEF);
        chk("t3_sob", bus.bb_sob, 1);
        chk("t3_eob0", bus.bb_eob, 0);

        // Consume 17 while accepting 100 bits at fill 80
        bus.wf_lanes_valid   = 1'b1;
        bus.wf_lanes_numbits = 8'd100;
        bus.wf_lanes_data    = ones;
        bus.bb_consume       = 7'd17;
        tick();
        bus.wf_lanes_valid = 1'b0;
        bus.bb_consume     = '0;
        chk("t4_fill163", bus.bb_fill, 163);
        chk("t4_data", bus.bb_data, 64'hD5E68091A2B3C4D5);
        chk("t4_ready0", bus.lanes_wf_ready, 0);
        chk("t4_sob0", bus.bb_sob, 0);
        chk("t4_ovr", bus.bb_overrun_err, 0);

        // Drain to 35, illegal consume while !bb_valid, then end the block
        bus.bb_consume = 7'd64;
        tick();
        chk("t5_fill99", bus.bb_fill, 99);
        tick();
        bus.bb_consume = '0;
        chk("t5_fill35", bus.bb_fill, 35);
        chk("t5_valid0", bus.bb_valid, 0);
        chk("t5_data35", bus.bb_data, 64'h7_FFFFFFFF);
        bus.bb_consume = 7'd5;
        tick();
        bus.bb_consume = '0;
        chk("t5_ovr_novalid", bus.bb_overrun_err, 1);
        chk("t5_fill_kept", bus.bb_fill, 35);
        tick();
        chk("t5_ovr_pulse", bus.bb_overrun_err, 0);
        bus.wf_lanes_valid   = 1'b1;
        bus.wf_lanes_numbits = 8'd0;
        bus.wf_lanes_eob     = 1'b1;
        bus.wf_lanes_eof     = 1'b1;
        bus.wf_lanes_errcode = ZIP_EOF_ERR;
        tick();
        bus.wf_lanes_valid   = 1'b0;
        bus.wf_lanes_eob     = 1'b0;
        bus.wf_lanes_eof     = 1'b0;
        bus.wf_lanes_errcode = ZIP_NO_ERR;
        chk("t5_valid_end", bus.bb_valid, 1);
        chk("t5_fill_end", bus.bb_fill, 35);
        chk("t5_eob", bus.bb_eob, 1);
        chk("t5_eof", bus.bb_eof, 1);
        chk("t5_errcode", bus.bb_errcode, ZIP_EOF_ERR);
        chk("t5_ready0", bus.lanes_wf_ready, 0);
        bus.bb_consume = 7'd15;
        tick();
        chk("t5_fill20", bus.bb_fill, 20);
        chk("t5_data20", bus.bb_data, 64'hFFFFF);
        chk("t5_ovr0", bus.bb_overrun_err, 0);
        bus.bb_consume = 7'd64;
        tick();
        bus.bb_consume = '0;
        chk("t5_ovr_big", bus.bb_overrun_err, 1);
        chk("t5_fill0", bus.bb_fill, 0);
        chk("t5_ready1", bus.lanes_wf_ready, 1);
        chk("t5_eob_clr", bus.bb_eob, 0);
        tick();
        chk("t5_ovr_clr", bus.bb_overrun_err, 0);

        // Oversized numbits clamps to 128, then fill 200 with end pending
        bus.wf_lanes_valid   = 1'b1;
        bus.wf_lanes_numbits = 8'd200;
        bus.wf_lanes_data    = pa;
        tick();
        chk("t6_ovr_nb", bus.bb_overrun_err, 1);
        chk("t6_fill128", bus.bb_fill, 128);
        chk("t6_data", bus.bb_data, pa[63:0]);
        bus.wf_lanes_numbits = 8'd72;
        bus.wf_lanes_data    = pb;
        bus.wf_lanes_eob     = 1'b1;
        tick();
        bus.wf_lanes_valid = 1'b0;
        bus.wf_lanes_eob   = 1'b0;
        chk("t6_fill200", bus.bb_fill, 200);
        chk("t6_eob_far", bus.bb_eob, 0);
        chk("t6_ready0", bus.lanes_wf_ready, 0);
        chk("t6_ovr0", bus.bb_overrun_err, 0);

        // Reset mid-block
        rst = 1'b1;
        tick();
        chk("t6_rst_fill", bus.bb_fill, 0);
        chk("t6_rst_valid", bus.bb_valid, 0);
        chk("t6_rst_ready", bus.lanes_wf_ready, 0);
        chk("t6_rst_data", bus.bb_data, 64'h0);
        tick();
        chk("t6_rst_ready_hold", bus.lanes_wf_ready, 0);
        rst = 1'b0;
        #1;
        chk("t6_ready_after", bus.lanes_wf_ready, 1);

        // Empty block end marker
        tick();
        bus.wf_lanes_valid   = 1'b1;
        bus.wf_lanes_numbits = 8'd0;
        bus.wf_lanes_eob     = 1'b1;
        tick();
        bus.wf_lanes_valid = 1'b0;
        bus.wf_lanes_eob   = 1'b0;
        chk("t7_marker_valid", bus.bb_valid, 1);
        chk("t7_marker_eob", bus.bb_eob, 1);
        chk("t7_marker_fill", bus.bb_fill, 0);
        chk("t7_marker_ready", bus.lanes_wf_ready, 0);
        tick();
        chk("t7_after_valid", bus.bb_valid, 0);
        chk("t7_after_eob", bus.bb_eob, 0);
        chk("t7_after_ready", bus.lanes_wf_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
